// File: rtl/password_ram_rom_pkg.sv
// Shared definitions for password-gated storage blocks: default widths,
// access passwords and the decoded access target.
package password_store_pkg;

  localparam int DATA_W = 8;
  localparam int PW_W   = 8;

  localparam logic [PW_W-1:0] RAM_PASSWORD = 8'hBF;
  localparam logic [PW_W-1:0] ROM_PASSWORD = 8'h3E;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_ROM  = 2'd2
  } target_t;

endpackage

// File: rtl/password_ram_rom_if.sv
// Register-style access bus for the password-gated RAM/ROM store.
interface password_ram_rom_if #(
  parameter int DATA_W = 8,
  parameter int PW_W   = 8
);

  logic [PW_W-1:0]   password_input;
  logic [DATA_W-1:0] data_input;
  logic              write_enable;
  logic              read_enable;
  logic [DATA_W-1:0] data_output;
  logic              auth_ok;
  logic              rom_locked;

  modport master (
    output password_input, data_input, write_enable, read_enable,
    input  data_output, auth_ok, rom_locked
  );

  modport slave (
    input  password_input, data_input, write_enable, read_enable,
    output data_output, auth_ok, rom_locked
  );

endinterface

// File: rtl/password_ram_rom_decode.sv
// Pure combinational password decoder; RAM wins if both passwords coincide.
module password_decode
  import password_store_pkg::*;
#(
  parameter int              PW_W   = 8,
  parameter logic [PW_W-1:0] RAM_PW = 8'hBF,
  parameter logic [PW_W-1:0] ROM_PW = 8'h3E
) (
  input  logic [PW_W-1:0] password,
  output target_t         target
);

  always_comb begin
    target = TGT_NONE;
    if (password == RAM_PW)      target = TGT_RAM;
    else if (password == ROM_PW) target = TGT_ROM;
  end

endmodule

// File: rtl/password_ram_rom.sv
// Password-gated store: one rewritable RAM word, one OTP ROM word that
// locks after its first program since reset, and a registered read port.
module password_ram_rom
  import password_store_pkg::*;
#(
  parameter int                DATA_W       = password_store_pkg::DATA_W,
  parameter int                PW_W         = password_store_pkg::PW_W,
  parameter logic [PW_W-1:0]   RAM_PASSWORD = password_store_pkg::RAM_PASSWORD,
  parameter logic [PW_W-1:0]   ROM_PASSWORD = password_store_pkg::ROM_PASSWORD
) (
  input logic               clk,
  input logic               rst,
  password_ram_rom_if.slave bus
);

  logic [DATA_W-1:0] ram_word;
  logic [DATA_W-1:0] rom_word;
  logic [DATA_W-1:0] data_q;
  logic              auth_q;
  logic              locked_q;
  target_t           target;

  password_decode #(
    .PW_W   (PW_W),
    .RAM_PW (RAM_PASSWORD),
    .ROM_PW (ROM_PASSWORD)
  ) u_decode (
    .password (bus.password_input),
    .target   (target)
  );

  // Nonblocking updates give read-before-write when both enables are high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_word <= '0;
      rom_word <= '0;
      data_q   <= '0;
      auth_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      if (bus.write_enable) begin
        if (target == TGT_RAM) begin
          ram_word <= bus.data_input;
        end else if (target == TGT_ROM && !locked_q) begin
          rom_word <= bus.data_input;
          locked_q <= 1'b1;
        end
      end
      if (bus.read_enable) begin
        case (target)
          TGT_RAM: data_q <= ram_word;
          TGT_ROM: data_q <= rom_word;
          default: data_q <= '0;
        endcase
      end
      if (bus.write_enable || bus.read_enable)
        auth_q <= (target != TGT_NONE);
    end
  end

  assign bus.data_output = data_q;
  assign bus.auth_ok     = auth_q;
  assign bus.rom_locked  = locked_q;

endmodule

// File: tb/tb_password_ram_rom.sv
// Bench for password_ram_rom: directed vector table, async-reset corner
// cases and random traffic against a behavioural model.
module tb_password_ram_rom;

  localparam logic [7:0] PW_RAM = 8'hBF;
  localparam logic [7:0] PW_ROM = 8'h3E;

  typedef struct {
    logic [7:0] pw;
    logic [7:0] din;
    logic       we;
    logic       re;
    logic [7:0] exp_dout;
    logic       exp_auth;
    logic       exp_locked;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  password_ram_rom_if #(.DATA_W(8), .PW_W(8)) bus ();

  password_ram_rom dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] m_ram, m_rom, m_dout;
  logic       m_auth, m_programmed;

  task automatic model_reset();
    m_ram = 8'h00; m_rom = 8'h00; m_dout = 8'h00;
    m_auth = 1'b0; m_programmed = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] pw, input logic [7:0] din,
                            input logic we, input logic re);
    logic [7:0] rd;
    logic is_ram, is_rom;
    is_ram = (pw == PW_RAM);
    is_rom = !is_ram && (pw == PW_ROM);
    rd = is_ram ? m_ram : (is_rom ? m_rom : 8'h00);
    if (re) m_dout = rd;
    if (we && is_ram) m_ram = din;
    if (we && is_rom && !m_programmed) begin
      m_rom = din;
      m_programmed = 1'b1;
    end
    if (we || re) m_auth = is_ram || is_rom;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [7:0] pw, input logic [7:0] din,
                       input logic we, input logic re);
    @(negedge clk);
    bus.password_input = pw;
    bus.data_input     = din;
    bus.write_enable   = we;
    bus.read_enable    = re;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_dout"},   bus.data_output,       m_dout);
    check({tag, "_auth"},   {7'd0, bus.auth_ok},    {7'd0, m_auth});
    check({tag, "_locked"}, {7'd0, bus.rom_locked}, {7'd0, m_programmed});
  endtask

  vec_t tbl[$];

  function automatic void add(input logic [7:0] pw, input logic [7:0] din,
                              input logic we, input logic re,
                              input logic [7:0] ed, input logic ea, input logic el);
    vec_t v;
    v.pw = pw; v.din = din; v.we = we; v.re = re;
    v.exp_dout = ed; v.exp_auth = ea; v.exp_locked = el;
    tbl.push_back(v);
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.password_input = 8'h00;
    bus.data_input     = 8'h00;
    bus.write_enable   = 1'b0;
    bus.read_enable    = 1'b0;
    model_reset();

    //   pw      din    we re  dout   auth locked
    add(PW_RAM, 8'h00, 0, 1, 8'h00, 1, 0);
    add(PW_ROM, 8'h00, 0, 1, 8'h00, 1, 0);
    add(8'hEE,  8'h9A, 1, 0, 8'h00, 0, 0);
    add(8'hEE,  8'h9A, 1, 0, 8'h00, 0, 0);
    add(PW_RAM, 8'h00, 0, 1, 8'h00, 1, 0);
    add(PW_RAM, 8'hDD, 1, 0, 8'h00, 1, 0);
    add(PW_RAM, 8'h00, 0, 1, 8'hDD, 1, 0);
    add(PW_RAM, 8'hBB, 1, 0, 8'hDD, 1, 0);
    add(PW_RAM, 8'h00, 0, 1, 8'hBB, 1, 0);
    add(8'h5B,  8'hCC, 1, 0, 8'hBB, 0, 0);
    add(PW_ROM, 8'h00, 0, 1, 8'h00, 1, 0);
    add(PW_ROM, 8'hCC, 1, 0, 8'h00, 1, 1);
    add(PW_ROM, 8'h00, 0, 1, 8'hCC, 1, 1);
    add(PW_ROM, 8'hFF, 1, 0, 8'hCC, 1, 1);
    add(PW_ROM, 8'h00, 0, 1, 8'hCC, 1, 1);
    add(PW_RAM, 8'h00, 0, 1, 8'hBB, 1, 1);
    add(8'h00,  8'h00, 0, 0, 8'hBB, 1, 1);
    add(PW_RAM, 8'h11, 1, 0, 8'hBB, 1, 1);
    add(PW_RAM, 8'h22, 1, 1, 8'h11, 1, 1);
    add(PW_RAM, 8'h00, 0, 1, 8'h22, 1, 1);
    add(8'h00,  8'h00, 0, 1, 8'h00, 0, 1);

    // Power-on reset, then confirm cleared state before any access
    rst = 1'b0;
    #3;
    check("async_rst_dout",   bus.data_output,       8'h00);
    check("async_rst_locked", {7'd0, bus.rom_locked}, 8'h00);
    do_reset();
    @(posedge clk); #1;
    check("rst_auth", {7'd0, bus.auth_ok}, 8'h00);

    foreach (tbl[i]) begin
      cycle(tbl[i].pw, tbl[i].din, tbl[i].we, tbl[i].re);
      check($sformatf("vec%0d_dout", i),   bus.data_output,       tbl[i].exp_dout);
      check($sformatf("vec%0d_auth", i),   {7'd0, bus.auth_ok},    {7'd0, tbl[i].exp_auth});
      check($sformatf("vec%0d_locked", i), {7'd0, bus.rom_locked}, {7'd0, tbl[i].exp_locked});
    end

    // Reset asserted in the middle of a held ROM write
    @(negedge clk);
    bus.password_input = PW_ROM;
    bus.data_input     = 8'h55;
    bus.write_enable   = 1'b1;
    bus.read_enable    = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("midrst_dout",   bus.data_output,       8'h00);
    check("midrst_locked", {7'd0, bus.rom_locked}, 8'h00);
    check("midrst_auth",   {7'd0, bus.auth_ok},    8'h00);
    @(negedge clk);
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    rst = 1'b1;
    cycle(PW_ROM, 8'h00, 0, 1);
    check("midrst_rom_cleared", bus.data_output, 8'h00);
    cycle(PW_ROM, 8'h77, 1, 0);
    check("reprog_locked", {7'd0, bus.rom_locked}, 8'h01);
    cycle(PW_ROM, 8'h00, 0, 1);
    check("reprog_read", bus.data_output, 8'h77);
    cycle(PW_RAM, 8'h00, 0, 1);
    check("midrst_ram_cleared", bus.data_output, 8'h00);

    // Random traffic against the model, with periodic resets to re-open the ROM
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int n = 0; n < 80; n++) begin
        logic [7:0] pw, din;
        logic we, re;
        case ($urandom_range(0, 3))
          0:       pw = PW_RAM;
          1:       pw = PW_ROM;
          default: pw = 8'($urandom);
        endcase
        din = 8'($urandom);
        we  = 1'($urandom);
        re  = 1'($urandom);
        cycle(pw, din, we, re);
        model_step(pw, din, we, re);
        check_model("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
